// File: rtl/disp_pkg.sv
// Shared constants for the digital-clock display stage: digit count,
// active-low seven-segment patterns and blink field encodings.
package disp_pkg;

  localparam int NUM_DIG = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    BLK_NONE = 2'b00,
    BLK_S    = 2'b01,
    BLK_MI   = 2'b10,
    BLK_H    = 2'b11
  } blk_sel_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_7seg_mux.sv
// Six-digit multiplexed seven-segment driver for hh:mm:ss with per-frame
// input snapshots, field blinking and global blanking. Outputs are registered.
module disp_7seg_mux
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_disp,
  input  logic [5:0] cnt_h,
  input  logic [5:0] cnt_mi,
  input  logic [5:0] cnt_s,
  input  logic [1:0] blink_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    DIG_LAST = 3'(NUM_DIG - 1);

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          blk_ph_q, blk_ph_d;
  logic [2:0]    dig_q, dig_d;
  logic [5:0]    snap_h_q, snap_h_d;
  logic [5:0]    snap_mi_q, snap_mi_d;
  logic [5:0]    snap_s_q, snap_s_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          blk_end;
  logic          dig_valid;
  logic          in_blink_field;
  logic [5:0]    field_val;
  logic [3:0]    bcd_digit;
  logic [6:0]    dec_seg;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick      = (ref_cnt_q == REF_LAST);
    ref_cnt_d = tick ? '0 : ref_cnt_q + 1'b1;

    dig_d = dig_q;
    if (tick) dig_d = (dig_q >= DIG_LAST) ? 3'd0 : dig_q + 3'd1;

    // Fresh data is captured as the last slot ends, so a whole frame shows one time value.
    snap_h_d  = snap_h_q;
    snap_mi_d = snap_mi_q;
    snap_s_d  = snap_s_q;
    if (tick && dig_q == DIG_LAST) begin
      snap_h_d  = cnt_h;
      snap_mi_d = cnt_mi;
      snap_s_d  = cnt_s;
    end

    blk_end   = (blk_cnt_q == BLK_LAST);
    blk_cnt_d = blk_end ? '0 : blk_cnt_q + 1'b1;
    blk_ph_d  = blk_ph_q ^ blk_end;
  end

  // Digit pairs: dig[2:1] picks the field (0 = s, 1 = mi, 2 = h), dig[0] picks tens.
  always_comb begin
    dig_valid = (dig_q <= DIG_LAST);
    case (dig_q[2:1])
      2'd0:    field_val = snap_s_q;
      2'd1:    field_val = snap_mi_q;
      2'd2:    field_val = snap_h_q;
      default: field_val = 6'd0;
    endcase
    bcd_digit = dig_q[0] ? 4'(field_val / 6'd10) : 4'(field_val % 6'd10);

    case (blk_sel_e'(blink_sel))
      BLK_S:   in_blink_field = (dig_q[2:1] == 2'd0);
      BLK_MI:  in_blink_field = (dig_q[2:1] == 2'd1);
      BLK_H:   in_blink_field = (dig_q[2:1] == 2'd2);
      default: in_blink_field = 1'b0;
    endcase
  end

  seg7_decode u_dec (
    .bcd (bcd_digit),
    .seg (dec_seg)
  );

  always_comb begin
    seg_d = dig_valid ? dec_seg : SEG_BLANK;
    dp_d  = !(dig_q == 3'd2 || dig_q == 3'd4);
    an_d  = 6'b111111;
    if (enable_disp && dig_valid && !(blk_ph_q && in_blink_field))
      an_d = ~(6'b000001 << dig_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_q <= '0;
      blk_cnt_q <= '0;
      blk_ph_q  <= 1'b0;
      dig_q     <= 3'd0;
      snap_h_q  <= 6'd0;
      snap_mi_q <= 6'd0;
      snap_s_q  <= 6'd0;
      an_q      <= 6'b111111;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      blk_ph_q  <= blk_ph_d;
      dig_q     <= dig_d;
      snap_h_q  <= snap_h_d;
      snap_mi_q <= snap_mi_d;
      snap_s_q  <= snap_s_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_disp_7seg_mux.sv
// Scoreboard bench for disp_7seg_mux: a cycle-count reference model predicts
// each registered output; a negedge monitor pops and compares.
module tb_disp_7seg_mux;

  localparam int R     = 4;
  localparam int B     = 32;
  localparam int FRAME = 6 * R;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable_disp = 1'b0;
  logic [5:0] cnt_h = '0, cnt_mi = '0, cnt_s = '0;
  logic [1:0] blink_sel = '0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  disp_7seg_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_disp (enable_disp),
    .cnt_h       (cnt_h),
    .cnt_mi      (cnt_mi),
    .cnt_s       (cnt_s),
    .blink_sel   (blink_sel),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: m_n = edges since reset release; slot, blink phase and
  // frame boundaries follow directly from integer division of that count.
  int unsigned m_n;
  int          m_snap [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n = 0;
      m_snap = '{0, 0, 0};
      exp_q.delete();
    end else begin
      int   slot, field, v, d;
      bit   blink_on;
      exp_t e;
      slot     = int'((m_n / R) % 6);
      field    = slot / 2;
      v        = m_snap[field];
      d        = (slot % 2 == 1) ? v / 10 : v % 10;
      blink_on = ((m_n / B) % 2 == 1) && (int'(blink_sel) == field + 1);
      e.seg    = seg_tab[d];
      e.dp     = (slot == 2 || slot == 4) ? 1'b0 : 1'b1;
      e.an     = (!enable_disp || blink_on) ? 6'h3f : ~(6'd1 << slot);
      exp_q.push_back(e);
      m_n++;
      if (m_n % FRAME == 0) begin
        m_snap[0] = int'(cnt_s);
        m_snap[1] = int'(cnt_mi);
        m_snap[2] = int'(cnt_h);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_an", 16'(an), 16'h003f);
      check("reset_seg", 16'(seg), 16'h007f);
      check("reset_dp", 16'(dp), 16'h0001);
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("an", 16'(an), 16'(e.an));
      check("seg", 16'(seg), 16'(e.seg));
      check("dp", 16'(dp), 16'(e.dp));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cnt_h = 6'd12; cnt_mi = 6'd34; cnt_s = 6'd56;
    enable_disp = 1'b1; blink_sel = 2'b00;
    run(3);
    #2 rst = 1'b1;

    // Frame 1 zeros, frame 2 shows 12:34:56; then change seconds mid-frame.
    run(2 * FRAME + 2 * R + 1);
    cnt_s = 6'd57;
    run(2 * FRAME);

    cnt_mi = 6'd63;
    run(2 * FRAME);

    blink_sel = 2'b10;
    run(4 * B);
    blink_sel = 2'b00;

    enable_disp = 1'b0;
    run(10);
    enable_disp = 1'b1;
    run(FRAME);

    for (int i = 0; i < 25; i++) begin
      cnt_h       = 6'($urandom_range(0, 63));
      cnt_mi      = 6'($urandom_range(0, 63));
      cnt_s       = 6'($urandom_range(0, 63));
      blink_sel   = 2'($urandom_range(0, 3));
      enable_disp = ($urandom_range(0, 4) != 0);
      run(int'($urandom_range(1, 40)));
    end

    // Asynchronous reset in the middle of slot 3.
    enable_disp = 1'b1; blink_sel = 2'b00;
    begin
      int budget;
      budget = 0;
      while (an !== 6'b110111 && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      check("wait_slot3_timeout", 16'(budget < 200), 16'h0001);
    end
    run(1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_an", 16'(an), 16'h003f);
    check("async_rst_seg", 16'(seg), 16'h007f);
    check("async_rst_dp", 16'(dp), 16'h0001);
    run(3);
    #2 rst = 1'b1;
    run(FRAME + 5);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_7seg_mux.md
# disp_7seg_mux

Display stage for the digital clock, downstream of the hour, minute and second counters. It takes the three 6-bit counts `cnt_h`, `cnt_mi` and `cnt_s`, converts each to two BCD digits, and time-multiplexes six common-anode seven-segment digits. Inputs are snapshotted once per scan frame so the display never tears. A field under adjustment can blink.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clk cycles per digit slot (≥2).
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period (≥2).

Ports:
- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `enable_disp`  in  1: 1 = display on; 0 = all digits blanked, counters keep running.
- `cnt_h`  in  6: hours count, binary.
- `cnt_mi`  in  6: minutes count, binary.
- `cnt_s`  in  6: seconds count, binary.
- `blink_sel`  in  2: field to blink. 00 = none, 01 = seconds, 10 = minutes, 11 = hours.
- `seg`  out  7: segments, active-low, {g,f,e,d,c,b,a}.
- `dp`  out  1: decimal point, active-low.
- `an`  out  6: digit enables, active-low; bit k = digit k.

## Operation
- Digit map: 0 = s units, 1 = s tens, 2 = mi units, 3 = mi tens, 4 = h units, 5 = h tens.
- Refresh counter `ref_cnt`:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - `tick` is asserted on the cycle `ref_cnt` = REFRESH_DIV-1.
- Digit index `dig` (3 bits):
  - Increments on `tick`, 5 → 0 wrap.
  - Values 6 and 7 are unreachable; if they occur, the next `tick` loads 0.
- Snapshot registers `snap_h`, `snap_mi`, `snap_s`:
  - Load all three inputs on the `tick` where `dig` = 5, so a new frame starts with fresh data.
  - Input changes mid-frame are invisible until the next frame.
- BCD conversion of the selected 6-bit value v:
  - tens = v/10, units = v mod 10.
  - Values 60..63 show tens 6, units 0..3; no clamping.
  - Hours are shown as-is; there is no leading-zero suppression.
- Segment patterns, active-low, {g..a}, digits 0–9:
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000, 4: 0011001
  - 5: 0010010, 6: 0000010, 7: 1111000, 8: 0000000, 9: 0010000
- `dp` = 0 when `dig` ∈ {2,4} (separator after hours and after minutes); otherwise 1.
- Blink:
  - Counter `blk_cnt` runs 0..BLINK_DIV-1; `blk_ph` toggles at terminal count.
  - When `blk_ph` = 1 and `dig` belongs to the field given by `blink_sel`, `an` = all 1 for that slot.
  - `seg` and `dp` are still driven while the slot is blanked.
- Blanking: when `enable_disp` = 0, `an` = 6'b111111.

## Timing
- Reset values:
  - `ref_cnt` = 0, `dig` = 0, `blk_cnt` = 0, `blk_ph` = 0, snapshots = 0.
  - `an` = 6'b111111, `seg` = 7'b1111111, `dp` = 1.
- `an`, `seg` and `dp` are registered. They reflect `dig`, the snapshots, `blink_sel` and `enable_disp` as they stood in the previous cycle, i.e. 1-cycle latency.
- After reset release:
  - First registered output: slot 0 with zero data (`an` = 111110, `seg` = 1000000), one cycle after the first edge.
  - First `tick` occurs on the REFRESH_DIV-th edge.
- Exactly one `an` bit is low at any time, or none (blanked). Slot changes happen on a single edge, with no overlap.
- `rst` asserted mid-frame: all state returns to reset values immediately (asynchronous). Scanning restarts at slot 0.
- Full frame = 6 × REFRESH_DIV cycles.
- `blink_sel` changes take effect on the next cycle, not at frame boundaries.

## Structure
- Shared package `disp_pkg`:
  - Digit-count constant NUM_DIG = 6.
  - The ten segment patterns plus SEG_BLANK.
  - `blink_sel` encodings BLK_NONE, BLK_S, BLK_MI, BLK_H.
- One sub-module, `seg7_decode`: combinational 4-bit BCD → 7-bit active-low pattern, instantiated once on the muxed digit.
- Top level holds the refresh, blink and index counters, the snapshots, the BCD split and the output registers.

## Test plan
Use REFRESH_DIV = 4, BLINK_DIV = 32 throughout.
- Reset, then `cnt_h` = 12, `cnt_mi` = 34, `cnt_s` = 56, `enable_disp` = 1, `blink_sel` = 00:
  - Frame 1 shows all zeros.
  - Frame 2 slots 0..5 show 6, 5, 4, 3, 2, 1.
  - `dp` = 0 only in slots 2 and 4.
  - Each `an` pattern holds exactly 4 cycles.
- Change `cnt_s` from 56 to 57 while slot 2 is active: the remainder of the frame is unchanged; the next frame's slot 0 shows 7.
- `cnt_mi` = 63: slots 3 and 2 show 6 and 3 (`seg` = 0000010, 0110000).
- `blink_sel` = 10: slots 2 and 3 have `an` = 111111 during `blk_ph` = 1 (32-cycle halves). Other slots are unaffected.
- `enable_disp` = 0: `an` = 111111 on the next cycle. On re-enable, scanning resumes at the current `dig` with no restart.
- Assert `rst` mid-slot 3: outputs return to reset values asynchronously, before the next edge. After release, slot 0 follows.
